// File: rtl/imem_boot_ctrl.sv
// ---------------------------------------------------------------------------
// imem_boot_ctrl
//   Instruction-memory controller for the pipelined core. Owns the
//   synchronous-read instruction RAM. In BOOT the program is streamed in
//   through the loader port while the core is held in reset. In RUN it
//   serves IF-stage fetches with one cycle of latency and accepts single-word
//   patch writes, each of which steals one fetch slot.
//
//   Optional feature macro: IMEM_LOAD_CHECKSUM_EN
//     defined   -> ld_checksum is the 32-bit modular sum of every word
//                  written during BOOT.
//     undefined -> ld_checksum is tied to zero.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   ld_wr_en/addr/data     loader write port (BOOT load or RUN patch)
//   ld_done                loader finished, leave BOOT
//   ld_ack                 one-cycle pulse the cycle after a loader write
//   fetch_req/fetch_addr   IF-stage request, byte address (PC)
//   fetch_ready            request accepted this cycle (combinational)
//   fetch_valid/instr      fetched word, one cycle after accept
//   fetch_fault            qualifies fetch_valid: misaligned or out of range
//   core_rst               holds the core in reset while in BOOT
//   boot_words             saturating count of BOOT writes
//   ld_checksum            BOOT image checksum (see macro above)
// ---------------------------------------------------------------------------
module imem_boot_ctrl #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_wr_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_done,
    output logic              ld_ack,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              fetch_fault,
    output logic              core_rst,
    output logic [ADDR_W:0]   boot_words,
    output logic [31:0]       ld_checksum
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [31:0]       mem_r [0:DEPTH-1];
    logic              wr_s;
    logic              accept_s;
    logic              fault_s;
    logic              ready_s;
    logic              ld_ack_r;
    logic              fetch_valid_r;
    logic              fetch_fault_r;
    logic [31:0]       fetch_instr_r;
    logic              core_rst_r;
    logic [ADDR_W:0]   boot_words_r;

    // Loader writes are blocked only while reset is asserted.
    assign wr_s = ld_wr_en && !reset;

    // Next-state logic and fetch handshake; a loader write always wins the slot.
    always_comb begin
        state_next_s = state_r;
        ready_s      = 1'b0;
        case (state_r)
            ST_BOOT: begin
                if (ld_done) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_BOOT;
                end
            end
            ST_RUN: begin
                state_next_s = ST_RUN;
                if (!ld_wr_en && !reset) begin
                    ready_s = 1'b1;
                end else begin
                    ready_s = 1'b0;
                end
            end
            default: begin
                state_next_s = ST_BOOT;
                ready_s      = 1'b0;
            end
        endcase
    end

    assign accept_s = fetch_req && ready_s;
    // Misaligned PC or any address bit above the RAM window faults the fetch.
    assign fault_s  = (fetch_addr[1:0] != 2'b00) || (|fetch_addr[31:ADDR_W+2]);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Instruction RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[ld_addr] <= ld_data;
        end
    end

    // Registered outputs: fetch response, loader ack, core reset, boot count.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_ack_r      <= 1'b0;
            fetch_valid_r <= 1'b0;
            fetch_fault_r <= 1'b0;
            fetch_instr_r <= 32'h0000_0000;
            core_rst_r    <= 1'b1;
            boot_words_r  <= {(ADDR_W+1){1'b0}};
        end else begin
            ld_ack_r      <= ld_wr_en;
            fetch_valid_r <= accept_s;
            fetch_fault_r <= accept_s && fault_s;
            core_rst_r    <= (state_next_s == ST_BOOT);
            if (accept_s) begin
                fetch_instr_r <= fault_s ? NOP_WORD : mem_r[fetch_addr[ADDR_W+1:2]];
            end else begin
                fetch_instr_r <= fetch_instr_r;
            end
            if ((state_r == ST_BOOT) && ld_wr_en && (boot_words_r != WORDS_MAX)) begin
                boot_words_r <= boot_words_r + {{ADDR_W{1'b0}}, 1'b1};
            end else begin
                boot_words_r <= boot_words_r;
            end
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] checksum_r;

    // Image checksum: accumulate BOOT writes only, patches are excluded.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_r <= 32'h0000_0000;
        end else if ((state_r == ST_BOOT) && ld_wr_en) begin
            checksum_r <= checksum_r + ld_data;
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign ld_checksum = checksum_r;
`else
    assign ld_checksum = 32'h0000_0000;
`endif

    assign fetch_ready = ready_s;
    assign ld_ack      = ld_ack_r;
    assign fetch_valid = fetch_valid_r;
    assign fetch_fault = fetch_fault_r;
    assign fetch_instr = fetch_instr_r;
    assign core_rst    = core_rst_r;
    assign boot_words  = boot_words_r;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for imem_boot_ctrl. A behavioural model (array memory,
// boot flag, counters) is advanced at each rising edge; a compare process
// checks every DUT output on each falling edge. Directed literal checks pin
// the model to hand-computed values from the program sequences below.
// ---------------------------------------------------------------------------
module tb_imem_boot_ctrl;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_wr_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              ld_done;
    logic              ld_ack;
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic              fetch_fault;
    logic              core_rst;
    logic [ADDR_W:0]   boot_words;
    logic [31:0]       ld_checksum;

    imem_boot_ctrl #(.ADDR_W(ADDR_W), .NOP_WORD(32'h00000013)) dut (
        .clk(clk), .reset(reset),
        .ld_wr_en(ld_wr_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_done(ld_done), .ld_ack(ld_ack),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
        .core_rst(core_rst), .boot_words(boot_words), .ld_checksum(ld_checksum)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model state
    bit          m_live = 1'b0;
    bit          m_run;
    bit          m_core_rst;
    bit          m_valid;
    bit          m_fault;
    bit          m_ack;
    logic [31:0] m_instr;
    int          m_words;
    logic [31:0] m_sum;
    logic [31:0] mem_m [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs as the DUT samples them.
    task automatic model_step();
        bit acc;
        bit bad;
        if (reset) begin
            m_live = 1'b1; m_run = 1'b0; m_core_rst = 1'b1; m_valid = 1'b0;
            m_fault = 1'b0; m_ack = 1'b0; m_instr = 32'h0; m_words = 0; m_sum = 32'h0;
        end else begin
            acc = m_run && !ld_wr_en && fetch_req;
            if (acc) begin
                bad     = (fetch_addr % 4 != 0) || (fetch_addr >= 32'h400);
                m_valid = 1'b1;
                m_fault = bad;
                m_instr = bad ? 32'h00000013 : mem_m[fetch_addr / 4];
            end else begin
                m_valid = 1'b0;
                m_fault = 1'b0;
            end
            m_ack = ld_wr_en;
            if (ld_wr_en) begin
                mem_m[ld_addr] = ld_data;
                if (!m_run) begin
                    if (m_words < 256) m_words++;
                    m_sum = m_sum + ld_data;
                end
            end
            if (!m_run && ld_done) m_run = 1'b1;
            m_core_rst = !m_run;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Compare process: every output against the model on each falling edge.
    initial begin
        logic [31:0] exp_sum;
        forever begin
            @(negedge clk);
            if (m_live) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                exp_sum = m_sum;
`else
                exp_sum = 32'h0;
`endif
                chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, m_run && !ld_wr_en && !reset});
                chk("core_rst",    {31'b0, core_rst},    {31'b0, m_core_rst});
                chk("ld_ack",      {31'b0, ld_ack},      {31'b0, m_ack});
                chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_valid});
                chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
                chk("fetch_instr", fetch_instr, m_instr);
                chk("boot_words",  {23'b0, boot_words}, m_words);
                chk("ld_checksum", ld_checksum, exp_sum);
            end
        end
    end

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5, 6: rand_pc = {22'b0, r[7:0], 2'b00};
            7:                   rand_pc = {22'b0, r[7:0], 2'b00} | {30'b0, r[9:8]};
            8:                   rand_pc = r;
            default:             rand_pc = 32'h400 + {22'b0, r[7:0], 2'b00};
        endcase
    endfunction

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            ld_wr_en   = ($urandom_range(0, 99) < 15);
            ld_addr    = 8'($urandom);
            ld_data    = $urandom;
            ld_done    = ($urandom_range(0, 9) == 0);
            fetch_req  = ($urandom_range(0, 99) < 75);
            fetch_addr = rand_pc();
            tick();
        end
        ld_wr_en = 1'b0; ld_done = 1'b0; fetch_req = 1'b0;
    endtask

    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h08000313; prog[1] = 32'h00032383;
        prog[2] = 32'h3e800093; prog[3] = 32'h7d008113;
        reset = 1'b1; ld_wr_en = 1'b0; ld_addr = '0; ld_data = 32'h0;
        ld_done = 1'b0; fetch_req = 1'b0; fetch_addr = 32'h0;
        tick(); tick();
        chk("rst_core_rst", {31'b0, core_rst}, 32'd1);
        chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
        chk("rst_instr", fetch_instr, 32'h0);
        chk("rst_words", {23'b0, boot_words}, 32'd0);
        chk("rst_checksum", ld_checksum, 32'h0);
        reset = 1'b0;

        // Fill whole RAM plus extra writes to hit saturation; fetches ignored in BOOT.
        for (int i = 0; i < 260; i++) begin
            ld_wr_en = 1'b1; ld_addr = 8'(i); ld_data = $urandom;
            fetch_req = $urandom_range(0, 1); fetch_addr = rand_pc();
            tick();
        end
        ld_wr_en = 1'b0; fetch_req = 1'b0;
        tick();
        chk("sat_words", {23'b0, boot_words}, 32'd256);

        // Write and done in the same cycle.
        ld_wr_en = 1'b1; ld_done = 1'b1; ld_addr = 8'd5; ld_data = 32'hCAFE0001;
        fetch_req = 1'b1; fetch_addr = 32'h14;
        tick();
        ld_wr_en = 1'b0; ld_done = 1'b0;
        chk("wd_ack", {31'b0, ld_ack}, 32'd1);
        chk("wd_core_rst", {31'b0, core_rst}, 32'd0);
        chk("wd_valid_boot", {31'b0, fetch_valid}, 32'd0);
        tick();
        chk("wd_fetch", fetch_instr, 32'hCAFE0001);
        fetch_req = 1'b0;

        random_run(300);

        // Directed program load.
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld_wr_en = 1'b1; ld_addr = 8'(i); ld_data = prog[i];
            tick();
            chk("load_ack", {31'b0, ld_ack}, 32'd1);
        end
        ld_wr_en = 1'b0; ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        chk("load_words", {23'b0, boot_words}, 32'd4);
        chk("load_core_rst", {31'b0, core_rst}, 32'd0);
`ifdef IMEM_LOAD_CHECKSUM_EN
        chk("load_checksum", ld_checksum, 32'hC383A83C);
`else
        chk("load_checksum", ld_checksum, 32'h0);
`endif

        // Back-to-back fetches.
        for (int k = 0; k < 4; k++) begin
            fetch_req = 1'b1; fetch_addr = 32'(4 * k);
            #1 chk("b2b_ready", {31'b0, fetch_ready}, 32'd1);
            tick();
            chk("b2b_valid", {31'b0, fetch_valid}, 32'd1);
            chk("b2b_instr", fetch_instr, prog[k]);
            chk("b2b_fault", {31'b0, fetch_fault}, 32'd0);
        end

        // Faulted fetches.
        fetch_addr = 32'h2; tick();
        chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
        chk("mis_instr", fetch_instr, 32'h00000013);
        fetch_addr = 32'h400; tick();
        chk("oor_fault", {31'b0, fetch_fault}, 32'd1);
        chk("oor_valid", {31'b0, fetch_valid}, 32'd1);
        chk("oor_instr", fetch_instr, 32'h00000013);

        // Patch write colliding with fetch of the same word.
        ld_wr_en = 1'b1; ld_addr = 8'd1; ld_data = 32'h12345237; fetch_addr = 32'h4;
        #1 chk("patch_ready", {31'b0, fetch_ready}, 32'd0);
        tick();
        ld_wr_en = 1'b0;
        chk("patch_ack", {31'b0, ld_ack}, 32'd1);
        chk("patch_valid", {31'b0, fetch_valid}, 32'd0);
        tick();
        chk("patch_instr", fetch_instr, 32'h12345237);
        chk("patch_words", {23'b0, boot_words}, 32'd4);

        // Reset mid-RUN during a fetch; program must survive.
        fetch_addr = 32'h0; reset = 1'b1;
        tick();
        reset = 1'b0; fetch_req = 1'b0;
        chk("mr_core_rst", {31'b0, core_rst}, 32'd1);
        chk("mr_valid", {31'b0, fetch_valid}, 32'd0);
        ld_done = 1'b1; tick(); ld_done = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        tick();
        fetch_req = 1'b0;
        chk("mr_instr", fetch_instr, 32'h08000313);
        chk("mr_words", {23'b0, boot_words}, 32'd0);

        random_run(300);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
